// File: rtl/checkpoint_ctrl.sv
// -----------------------------------------------------------------------------
// checkpoint_ctrl
//
// Allocation controller for the rename checkpoint array. Slot indices are
// handed out in circular-FIFO order:
//   - rename saves a checkpoint and is granted the tail slot,
//   - ROB commit frees the oldest live slot (the head),
//   - a mispredict restore releases the named slot and every younger slot.
//
// Head and tail are kept as (IW+1)-bit pointers. The MSB is a wrap bit, so
// a full queue (same index, different wrap) is distinct from an empty one
// (identical pointers).
//
// Ports
//   CLK            clock
//   nRST           synchronous, active-low reset
//   save_valid     rename requests a new checkpoint
//   save_ready     a slot is available and no restore is in progress
//   save_index     slot granted when save_valid & save_ready (tail index)
//   restore_valid  mispredict rollback request
//   restore_index  slot being restored (it and all younger slots released)
//   free_valid     commit releases the head slot
//   free_index     expected head slot, checked against the real head
//   head_index     oldest live slot
//   count          number of live slots, 0..CHECKPOINT_COUNT
//   empty / full   count == 0 / count == CHECKPOINT_COUNT
//   restore_err    one-cycle pulse: an illegal restore was dropped
//   free_err       one-cycle pulse: free on empty, or free_index != head
//   stall_cycles   saturating count of cycles with save_valid & !save_ready
//
// Build option
//   CHECKPOINT_CTRL_STALL_CNT_EN  when defined, adds the stall_cycles port
//                                 and its 32-bit saturating counter.
// -----------------------------------------------------------------------------
module checkpoint_ctrl #(
  parameter int CHECKPOINT_COUNT       = 8,
  parameter int CHECKPOINT_INDEX_WIDTH = $clog2(CHECKPOINT_COUNT)
) (
  input  logic                              CLK,
  input  logic                              nRST,
  input  logic                              save_valid,
  output logic                              save_ready,
  output logic [CHECKPOINT_INDEX_WIDTH-1:0] save_index,
  input  logic                              restore_valid,
  input  logic [CHECKPOINT_INDEX_WIDTH-1:0] restore_index,
  input  logic                              free_valid,
  input  logic [CHECKPOINT_INDEX_WIDTH-1:0] free_index,
  output logic [CHECKPOINT_INDEX_WIDTH-1:0] head_index,
  output logic [CHECKPOINT_INDEX_WIDTH:0]   count,
  output logic                              empty,
  output logic                              full,
  output logic                              restore_err,
  output logic                              free_err
`ifdef CHECKPOINT_CTRL_STALL_CNT_EN
  ,
  output logic [31:0]                       stall_cycles
`endif
);

  localparam int IW = CHECKPOINT_INDEX_WIDTH;
  localparam logic [IW:0] PTR_ONE = (IW+1)'(1);

  logic [IW:0]   head_ptr, tail_ptr;
  logic [IW:0]   head_ptr_nxt, tail_ptr_nxt;
  logic [IW-1:0] head_idx;
  logic [IW-1:0] restore_offset;
  logic          restore_legal;
  logic          restore_empties;
  logic          free_legal;
  logic          save_fire;
  logic          restore_err_nxt, free_err_nxt;

  // ---------------------------------------------------------------------------
  // Occupancy and status
  // ---------------------------------------------------------------------------
  assign head_idx   = head_ptr[IW-1:0];
  assign count      = tail_ptr - head_ptr;
  assign empty      = (head_ptr == tail_ptr);
  assign full       = (head_idx == tail_ptr[IW-1:0]) && (head_ptr[IW] != tail_ptr[IW]);
  assign head_index = head_idx;
  assign save_index = tail_ptr[IW-1:0];

  // A restore blocks saves for the whole cycle so the tail is never moved by
  // both a rollback and an allocation at once.
  assign save_ready = !full && !restore_valid;
  assign save_fire  = save_valid && save_ready;

  // Age of the restored slot relative to head, modulo the slot count. It is
  // live only if that age is below the current occupancy.
  assign restore_offset  = restore_index - head_idx;
  assign restore_legal   = ({1'b0, restore_offset} < count);
  // Restoring the head slot empties the queue; a same-cycle free of that slot
  // has nothing left to release and is dropped without an error.
  assign restore_empties = restore_valid && restore_legal && (restore_offset == '0);

  assign free_legal = !empty && (free_index == head_idx);

  // ---------------------------------------------------------------------------
  // Next-state: restore > free > save
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    head_ptr_nxt    = head_ptr;
    tail_ptr_nxt    = tail_ptr;
    restore_err_nxt = 1'b0;
    free_err_nxt    = 1'b0;

    if (restore_valid) begin
      if (restore_legal) begin
        // Offset is taken from the pre-free head, so a same-cycle free does
        // not shift the restore point.
        tail_ptr_nxt = head_ptr + {1'b0, restore_offset};
      end else begin
        restore_err_nxt = 1'b1;
      end
    end

    if (free_valid && !restore_empties) begin
      if (free_legal) begin
        head_ptr_nxt = head_ptr + PTR_ONE;
      end else begin
        free_err_nxt = 1'b1;
      end
    end

    // save_ready already excludes restore_valid, so this never collides with
    // the restore assignment above.
    if (save_fire) begin
      tail_ptr_nxt = tail_ptr + PTR_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: reset is sampled on the clock edge (synchronous), and all state uses
  // non-blocking assignment so every register updates from pre-edge values.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      head_ptr    <= '0;
      tail_ptr    <= '0;
      restore_err <= 1'b0;
      free_err    <= 1'b0;
    end else begin
      head_ptr    <= head_ptr_nxt;
      tail_ptr    <= tail_ptr_nxt;
      restore_err <= restore_err_nxt;
      free_err    <= free_err_nxt;
    end
  end

`ifdef CHECKPOINT_CTRL_STALL_CNT_EN
  // Saturating count of cycles where rename wanted a slot but was refused.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_cycles <= '0;
    end else if (save_valid && !save_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_checkpoint_ctrl.sv
// -----------------------------------------------------------------------------
// tb_checkpoint_ctrl
//
// Directed stimulus for checkpoint_ctrl. A queue of live slot indices models
// the controller; a compare process checks every DUT output against it on
// each falling edge, and the directed sequence adds literal expectations at
// key points.
// -----------------------------------------------------------------------------
module tb_checkpoint_ctrl;

  localparam int N  = 8;
  localparam int IW = 3;

  logic          CLK;
  logic          nRST;
  logic          save_valid;
  logic          save_ready;
  logic [IW-1:0] save_index;
  logic          restore_valid;
  logic [IW-1:0] restore_index;
  logic          free_valid;
  logic [IW-1:0] free_index;
  logic [IW-1:0] head_index;
  logic [IW:0]   count;
  logic          empty;
  logic          full;
  logic          restore_err;
  logic          free_err;
`ifdef CHECKPOINT_CTRL_STALL_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  checkpoint_ctrl #(.CHECKPOINT_COUNT(N)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .save_valid   (save_valid),
    .save_ready   (save_ready),
    .save_index   (save_index),
    .restore_valid(restore_valid),
    .restore_index(restore_index),
    .free_valid   (free_valid),
    .free_index   (free_index),
    .head_index   (head_index),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .restore_err  (restore_err),
    .free_err     (free_err)
`ifdef CHECKPOINT_CTRL_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: live slots as a queue, oldest first
  // ---------------------------------------------------------------------------
  int          m_q[$];
  int          m_head;
  bit          m_rerr, m_ferr;
  logic [31:0] m_stall;
  bit          m_valid = 0;
  int          m_pos, m_tail;
  bit          m_ready, m_free_ok, m_free_drop;

  always @(posedge CLK) begin
    if (!nRST) begin
      m_q.delete();
      m_head  = 0;
      m_rerr  = 0;
      m_ferr  = 0;
      m_stall = 0;
    end else begin
      m_ready     = (m_q.size() < N) && !restore_valid;
      m_tail      = (m_head + m_q.size()) % N;
      m_free_ok   = free_valid && (m_q.size() > 0) && (m_q[0] == int'(free_index));
      m_free_drop = 0;
      m_rerr      = 0;
      m_ferr      = 0;
      if (save_valid && !m_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (restore_valid) begin
        m_pos = -1;
        for (int i = 0; i < m_q.size(); i++)
          if (m_q[i] == int'(restore_index)) m_pos = i;
        if (m_pos < 0) m_rerr = 1;
        else begin
          while (m_q.size() > m_pos) void'(m_q.pop_back());
          if (m_pos == 0) m_free_drop = 1;
        end
      end
      if (free_valid && !m_free_drop) begin
        if (m_free_ok) begin
          void'(m_q.pop_front());
          m_head = (m_head + 1) % N;
        end else begin
          m_ferr = 1;
        end
      end
      if (save_valid && m_ready) m_q.push_back(m_tail);
    end
    m_valid = 1;
  end

  // Compare process: outputs are stable at the falling edge.
  always @(negedge CLK) begin
    if (m_valid) begin
      check("count",       32'(count),       32'(m_q.size()));
      check("head_index",  32'(head_index),  32'(m_head));
      check("save_index",  32'(save_index),  32'((m_head + m_q.size()) % N));
      check("empty",       32'(empty),       32'(m_q.size() == 0));
      check("full",        32'(full),        32'(m_q.size() == N));
      check("save_ready",  32'(save_ready),  32'((m_q.size() < N) && !restore_valid));
      check("restore_err", 32'(restore_err), 32'(m_rerr));
      check("free_err",    32'(free_err),    32'(m_ferr));
`ifdef CHECKPOINT_CTRL_STALL_CNT_EN
      check("stall_cycles", stall_cycles, m_stall);
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: drive one cycle of requests, then return to idle
  // ---------------------------------------------------------------------------
  task automatic idle();
    save_valid    = 0;
    restore_valid = 0;
    restore_index = '0;
    free_valid    = 0;
    free_index    = '0;
  endtask

  task automatic cyc(input bit sv, input bit rv, input int ri, input bit fv, input int fi);
    save_valid    = sv;
    restore_valid = rv;
    restore_index = IW'(ri);
    free_valid    = fv;
    free_index    = IW'(fi);
    @(posedge CLK);
    #1;
    idle();
  endtask

  task automatic do_reset();
    nRST = 0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    nRST = 1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    idle();
    nRST = 0;
    do_reset();
    check("rst count", 32'(count), 0);
    check("rst empty", 32'(empty), 1);
    check("rst ready", 32'(save_ready), 1);
    check("rst head",  32'(head_index), 0);
    check("rst rerr",  32'(restore_err), 0);

    // Eight back-to-back saves grant 0..7 and fill the queue.
    for (int i = 0; i < N; i++) begin
      check("fill idx", 32'(save_index), 32'(i));
      cyc(1, 0, 0, 0, 0);
    end
    check("fill count", 32'(count), 8);
    check("fill full",  32'(full), 1);
    check("fill ready", 32'(save_ready), 0);

    // Free head plus save while full: save is refused this cycle (full).
    cyc(1, 0, 0, 1, 0);
    check("fs head",  32'(head_index), 1);
    check("fs count", 32'(count), 7);
    check("fs idx",   32'(save_index), 0);
    cyc(1, 0, 0, 0, 0);
    check("refill count", 32'(count), 8);

    // Free + save with room: count unchanged.
    cyc(0, 0, 0, 1, 1);
    cyc(1, 0, 0, 1, 2);
    check("fs2 count", 32'(count), 7);
    check("fs2 head",  32'(head_index), 3);
    check("fs2 idx",   32'(save_index), 2);

    // Free with wrong index.
    cyc(0, 0, 0, 1, 5);
    check("bad free err",   32'(free_err), 1);
    check("bad free count", 32'(count), 7);
    cyc(0, 0, 0, 0, 0);
    check("free err pulse", 32'(free_err), 0);

    // Reset mid-operation discards all slots.
    do_reset();
    check("rst2 count", 32'(count), 0);
    check("rst2 head",  32'(head_index), 0);

    // Build head=2, count=5 (slots 2..6).
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    check("setup head",  32'(head_index), 2);
    check("setup count", 32'(count), 5);

    // Restore of a dead slot is dropped.
    cyc(0, 1, 7, 0, 0);
    check("bad rst err",   32'(restore_err), 1);
    check("bad rst count", 32'(count), 5);
    cyc(0, 0, 0, 0, 0);
    check("rst err pulse", 32'(restore_err), 0);

    // Legal restore of slot 4 leaves slots 2,3.
    cyc(0, 1, 4, 0, 0);
    check("rest idx",   32'(save_index), 4);
    check("rest count", 32'(count), 2);
    check("rest head",  32'(head_index), 2);

    // Build head=3, count=2 then restore head + free head.
    cyc(0, 0, 0, 1, 2);
    cyc(1, 0, 0, 0, 0);
    check("h3 count", 32'(count), 2);
    cyc(0, 1, 3, 1, 3);
    check("rf empty", 32'(empty), 1);
    check("rf head",  32'(head_index), 3);
    check("rf tail",  32'(save_index), 3);
    check("rf ferr",  32'(free_err), 0);

    // Free on empty.
    cyc(0, 0, 0, 1, 3);
    check("empty ferr",  32'(free_err), 1);
    check("empty count", 32'(count), 0);

    // Restore of a younger slot plus free of head in the same cycle.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);   // slots 3,4,5
    cyc(0, 1, 5, 1, 3);
    check("rf2 head",  32'(head_index), 4);
    check("rf2 idx",   32'(save_index), 5);
    check("rf2 count", 32'(count), 1);

    // Wrap: indices continue 5,6,7,0,1,2,3.
    for (int i = 0; i < 7; i++) begin
      check("wrap idx", 32'(save_index), 32'((5 + i) % N));
      cyc(1, 0, 0, 0, 0);
    end
    check("wrap full", 32'(full), 1);

    // Restore across the wrap: head 4, slot 1 is offset 5.
    cyc(0, 1, 1, 0, 0);
    check("wrap rest count", 32'(count), 5);
    check("wrap rest idx",   32'(save_index), 1);

    // Stall counting: fresh reset, fill, hold save_valid 4 cycles while full.
    do_reset();
    for (int i = 0; i < N; i++) cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
    check("stall full",  32'(full), 1);
    check("stall count", 32'(count), 8);
`ifdef CHECKPOINT_CTRL_STALL_CNT_EN
    check("stall cycles", stall_cycles, 4);
`endif

    cyc(0, 0, 0, 0, 0);
    @(negedge CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
